// File: rtl/dcache_assoc_pkg.sv
// rtl/dcache_assoc_pkg.sv - shared types and constants for dcache_assoc
package dcache_assoc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_FETCH,
        ST_FL_SCAN,
        ST_FL_WB,
        ST_CNT,
        ST_DONE
    } dcache_state_t;

    localparam logic [31:0] HIT_ADDR_DEF = 32'h0000_3100;

endpackage

// File: rtl/dcache_assoc_lru_ages.sv
// rtl/dcache_assoc_lru_ages.sv - age-based true-LRU update and victim pick for one set
module dcache_lru_ages #(
    parameter int unsigned WAYS = 2,
    parameter int unsigned AW   = 1
) (
    input  logic [WAYS*AW-1:0] i_ages,
    input  logic [AW-1:0]      i_touch_way,
    input  logic               i_touch_en,
    output logic [WAYS*AW-1:0] o_ages_next,
    output logic [AW-1:0]      o_victim
);
    logic [AW-1:0] w_touch_age;

    always_comb begin
        w_touch_age = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == i_touch_way) w_touch_age = i_ages[w*AW +: AW];
        end
    end

    // Ages form a permutation of 0..WAYS-1; the oldest way is the victim.
    always_comb begin
        o_ages_next = i_ages;
        o_victim    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (i_ages[w*AW +: AW] == AW'(WAYS - 1)) o_victim = AW'(w);
            if (i_touch_en) begin
                if (AW'(w) == i_touch_way)
                    o_ages_next[w*AW +: AW] = '0;
                else if (i_ages[w*AW +: AW] < w_touch_age)
                    o_ages_next[w*AW +: AW] = i_ages[w*AW +: AW] + AW'(1);
            end
        end
    end

endmodule

// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - N-way write-back write-allocate data cache with LRU and flush
module dcache_assoc
    import dcache_assoc_pkg::*;
#(
    parameter int unsigned WAYS     = 2,
    parameter int unsigned SETS     = 8,
    parameter int unsigned WORDS    = 2,
    parameter logic [31:0] HIT_ADDR = HIT_ADDR_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    localparam int unsigned LW = $clog2(WORDS);
    localparam int unsigned LS = $clog2(SETS);
    localparam int unsigned LA = $clog2(WAYS);
    localparam int unsigned WW = (WORDS > 1) ? LW : 1;
    localparam int unsigned AW = (WAYS > 1) ? LA : 1;
    localparam int unsigned TW = 30 - LW - LS;
    localparam int unsigned NE = SETS * WAYS;
    localparam int unsigned IW = $clog2(NE);

    typedef struct packed {
        logic          valid;
        logic          dirty;
        logic [TW-1:0] tag;
    } dcache_line_t;

    dcache_line_t  r_meta [SETS][WAYS];
    logic [31:0]   r_data [SETS][WAYS][WORDS];
    logic [AW-1:0] r_age  [SETS][WAYS];

    dcache_state_t r_state, w_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_hits;
    logic [AW-1:0] r_victim;
    logic [WW-1:0] r_word;
    logic [IW-1:0] r_idx;

    logic [LS-1:0]      w_req_set, w_r_set, w_fl_set;
    logic [TW-1:0]      w_req_tag, w_r_tag;
    logic [WW-1:0]      w_req_word;
    logic [AW-1:0]      w_fl_way, w_hit_way, w_inv_way, w_lru_victim, w_victim;
    logic               w_req, w_is_wr, w_hit, w_inv_found, w_hit_fire;
    logic               w_xfer_done, w_last_word, w_last_entry, w_fl_dirty;
    logic [WAYS*AW-1:0] w_set_ages, w_next_ages;
    dcache_line_t       w_vic_line, w_fl_line;

    function automatic logic [31:0] mk_addr(input logic [TW-1:0] t, input logic [LS-1:0] s,
                                            input logic [WW-1:0] w);
        return (32'(t) << (2 + LW + LS)) | (32'(s) << (2 + LW)) | ((32'(w) & 32'(WORDS - 1)) << 2);
    endfunction

    assign w_req      = dmemREN | dmemWEN;
    assign w_is_wr    = dmemWEN & ~dmemREN;
    assign w_req_word = WW'((dmemaddr >> 2) & 32'(WORDS - 1));
    assign w_req_set  = LS'(dmemaddr >> (2 + LW));
    assign w_req_tag  = TW'(dmemaddr >> (2 + LW + LS));
    assign w_r_set    = LS'(r_addr >> (2 + LW));
    assign w_r_tag    = TW'(r_addr >> (2 + LW + LS));
    assign w_fl_set   = LS'(r_idx >> LA);
    assign w_fl_way   = AW'(r_idx & IW'(WAYS - 1));

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_meta[w_req_set][w].valid && r_meta[w_req_set][w].tag == w_req_tag) begin
                w_hit     = 1'b1;
                w_hit_way = AW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_meta[w_req_set][w].valid) begin
                w_inv_found = 1'b1;
                w_inv_way   = AW'(w);
            end
        end
    end

    always_comb begin
        w_set_ages = '0;
        for (int w = 0; w < WAYS; w++) w_set_ages[w*AW +: AW] = r_age[w_req_set][w];
    end

    dcache_lru_ages #(.WAYS(WAYS), .AW(AW)) u_lru (
        .i_ages      (w_set_ages),
        .i_touch_way (w_hit_way),
        .i_touch_en  (w_hit_fire),
        .o_ages_next (w_next_ages),
        .o_victim    (w_lru_victim)
    );

    assign w_hit_fire   = (r_state == ST_IDLE) && !halt && w_req && w_hit;
    assign w_victim     = w_inv_found ? w_inv_way : w_lru_victim;
    assign w_vic_line   = r_meta[w_req_set][w_victim];
    assign w_fl_line    = r_meta[w_fl_set][w_fl_way];
    assign w_fl_dirty   = w_fl_line.valid && w_fl_line.dirty;
    assign w_xfer_done  = (dREN | dWEN) & ~dwait;
    assign w_last_word  = (r_word == WW'(WORDS - 1));
    assign w_last_entry = (r_idx == IW'(NE - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (halt)
                    w_next = ST_FL_SCAN;
                else if (w_req && !w_hit)
                    w_next = (w_vic_line.valid && w_vic_line.dirty) ? ST_WB : ST_FETCH;
            end
            ST_WB:      if (w_xfer_done && w_last_word) w_next = ST_FETCH;
            ST_FETCH:   if (w_xfer_done && w_last_word) w_next = ST_IDLE;
            ST_FL_SCAN: begin
                if (w_fl_dirty)        w_next = ST_FL_WB;
                else if (w_last_entry) w_next = ST_CNT;
            end
            // The final entry has nothing left to scan, so its writeback goes straight on.
            ST_FL_WB:   if (w_xfer_done && w_last_word) w_next = w_last_entry ? ST_CNT : ST_FL_SCAN;
            ST_CNT:     if (w_xfer_done) w_next = ST_DONE;
            ST_DONE:    w_next = ST_DONE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hit_fire) begin
                    dhit     = 1'b1;
                    dmemload = r_data[w_req_set][w_hit_way][w_req_word];
                end
            end
            ST_WB: begin
                dWEN   = 1'b1;
                daddr  = mk_addr(r_meta[w_r_set][r_victim].tag, w_r_set, r_word);
                dstore = r_data[w_r_set][r_victim][r_word];
            end
            ST_FETCH: begin
                dREN  = 1'b1;
                daddr = mk_addr(w_r_tag, w_r_set, r_word);
            end
            ST_FL_WB: begin
                dWEN   = 1'b1;
                daddr  = mk_addr(w_fl_line.tag, w_fl_set, r_word);
                dstore = r_data[w_fl_set][w_fl_way][r_word];
            end
            ST_CNT: begin
                dWEN   = 1'b1;
                daddr  = HIT_ADDR;
                dstore = r_hits;
            end
            ST_DONE: flushed = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr   <= '0;
            r_hits   <= '0;
            r_victim <= '0;
            r_word   <= '0;
            r_idx    <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_meta[s][w] <= '0;
                    r_age[s][w]  <= AW'(w);
                    for (int k = 0; k < WORDS; k++) r_data[s][w][k] <= '0;
                end
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (halt) begin
                        r_idx  <= '0;
                        r_word <= '0;
                    end else if (w_hit_fire) begin
                        r_hits <= r_hits + 32'd1;
                        for (int w = 0; w < WAYS; w++) r_age[w_req_set][w] <= w_next_ages[w*AW +: AW];
                        if (w_is_wr) begin
                            r_data[w_req_set][w_hit_way][w_req_word] <= dmemstore;
                            r_meta[w_req_set][w_hit_way].dirty       <= 1'b1;
                        end
                    end else if (w_req) begin
                        r_addr   <= dmemaddr;
                        r_victim <= w_victim;
                        r_word   <= '0;
                    end
                end
                ST_WB: begin
                    if (w_xfer_done) r_word <= w_last_word ? '0 : r_word + WW'(1);
                end
                ST_FETCH: begin
                    if (w_xfer_done) begin
                        r_data[w_r_set][r_victim][r_word] <= dload;
                        r_word <= w_last_word ? '0 : r_word + WW'(1);
                        if (w_last_word) r_meta[w_r_set][r_victim] <= '{valid: 1'b1, dirty: 1'b0, tag: w_r_tag};
                    end
                end
                ST_FL_SCAN: begin
                    if (!w_fl_dirty) begin
                        r_meta[w_fl_set][w_fl_way].valid <= 1'b0;
                        r_idx <= r_idx + IW'(1);
                    end
                end
                ST_FL_WB: begin
                    if (w_xfer_done) begin
                        r_word <= w_last_word ? '0 : r_word + WW'(1);
                        if (w_last_word) begin
                            r_meta[w_fl_set][w_fl_way].valid <= 1'b0;
                            r_meta[w_fl_set][w_fl_way].dirty <= 1'b0;
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - self-checking bench for dcache_assoc (4-way, 8 sets, 2-word blocks)
module tb_dcache_assoc;
    localparam int W = 4;
    localparam int S = 8;
    localparam int N = 2;

    logic        CLK, RST, dmemREN, dmemWEN, halt, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    dcache_assoc #(.WAYS(W), .SETS(S), .WORDS(N), .HIT_ADDR(32'h0000_3100)) dut (
        .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload)
    );

    always #5 CLK = ~CLK;

    typedef struct { bit we; logic [31:0] a; logic [31:0] d; } txn_t;
    txn_t exp_q[$];
    txn_t act_q[$];

    logic [31:0] mem   [logic [31:0]];
    logic [31:0] g_mem [logic [31:0]];

    bit          m_valid [S][W];
    bit          m_dirty [S][W];
    logic [25:0] m_tag   [S][W];
    logic [31:0] m_data  [S][W][N];
    int          m_ord   [S][W];
    int          m_hits;

    int n_pass = 0, n_tot = 0;
    int wait_n, wcnt;
    bit chk_load, p_busy, p_wait;
    logic [31:0] exp_load, last_load, p_addr, p_store;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] rd_gmem(input logic [31:0] a);
        return g_mem.exists(a) ? g_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < S; s++)
            for (int w = 0; w < W; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; m_ord[s][w] = w;
                for (int k = 0; k < N; k++) m_data[s][w][k] = '0;
            end
        m_hits = 0;
    endtask

    // m_ord lists ways most-recently-used first.
    task automatic touch(input int s, input int hw);
        int p;
        p = 0;
        for (int i = 0; i < W; i++) if (m_ord[s][i] == hw) p = i;
        for (int i = p; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
        m_ord[s][0] = hw;
    endtask

    always @(posedge CLK) begin
        txn_t tx;
        if ((dREN || dWEN) && !dwait && !RST) begin
            tx.we = dWEN; tx.a = daddr; tx.d = dWEN ? dstore : dload;
            act_q.push_back(tx);
            if (dWEN) mem[daddr] = dstore;
            wcnt = 0;
        end
    end

    always @(negedge CLK) begin
        if (p_busy && p_wait) begin
            chk("stable_daddr", daddr, p_addr);
            chk("stable_dstore", dstore, p_store);
        end
        if (dREN || dWEN) chk("dhit_while_busy", dhit, 1'b0);
        if (dhit && chk_load) chk("dmemload", dmemload, exp_load);
        if ((dREN || dWEN) && wcnt < wait_n) begin dwait = 1; wcnt++; end
        else dwait = 0;
        dload   = rd_mem(daddr);
        p_busy  = dREN || dWEN;
        p_wait  = dwait;
        p_addr  = daddr;
        p_store = dstore;
    end

    task automatic cmp_txns(input string nm);
        chk({nm, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("%s_we%0d", nm, i), 32'(act_q[i].we), 32'(exp_q[i].we));
            chk($sformatf("%s_addr%0d", nm, i), act_q[i].a, exp_q[i].a);
            chk($sformatf("%s_data%0d", nm, i), act_q[i].d, exp_q[i].d);
        end
    endtask

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int s, wd, hw, v, cyc;
        bit got, miss;
        logic [25:0] t;
        logic [31:0] ea;
        s = int'(a[5:3]); wd = int'(a[2]); t = a[31:6];
        exp_q.delete(); act_q.delete();
        hw = -1;
        for (int w = 0; w < W; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        miss = (hw < 0);
        if (miss) begin
            v = -1;
            for (int w = W - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) v = m_ord[s][W-1];
            if (m_dirty[s][v])
                for (int k = 0; k < N; k++) begin
                    ea = {m_tag[s][v], 3'(s), 1'(k), 2'b00};
                    exp_q.push_back('{1'b1, ea, m_data[s][v][k]});
                    g_mem[ea] = m_data[s][v][k];
                end
            for (int k = 0; k < N; k++) begin
                ea = {t, 3'(s), 1'(k), 2'b00};
                m_data[s][v][k] = rd_gmem(ea);
                exp_q.push_back('{1'b0, ea, m_data[s][v][k]});
            end
            m_valid[s][v] = 1; m_dirty[s][v] = 0; m_tag[s][v] = t; hw = v;
        end
        touch(s, hw);
        m_hits++;
        if (wr) begin
            m_data[s][hw][wd] = d; m_dirty[s][hw] = 1; chk_load = 0;
        end else begin
            exp_load = m_data[s][hw][wd]; chk_load = 1;
        end
        @(posedge CLK); #1;
        dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = d;
        cyc = 0; got = 0;
        while (!got && cyc < 300) begin
            @(negedge CLK);
            if (dhit) begin got = 1; last_load = dmemload; end
            else cyc++;
        end
        @(posedge CLK); #1;
        dmemREN = 0; dmemWEN = 0; chk_load = 0;
        chk($sformatf("dhit_seen_%h", a), 32'(got), 32'd1);
        if (wait_n == 0) chk($sformatf("latency_%h", a), cyc, miss ? 1 + exp_q.size() : 0);
        cmp_txns($sformatf("txn_%h", a));
    endtask

    task automatic do_reset();
        RST = 1; p_busy = 0; wcnt = 0; dmemREN = 0; dmemWEN = 0; halt = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST = 0;
    endtask

    task automatic do_flush();
        int cyc;
        logic [31:0] ea;
        exp_q.delete(); act_q.delete();
        for (int s = 0; s < S; s++)
            for (int w = 0; w < W; w++) begin
                if (m_valid[s][w] && m_dirty[s][w])
                    for (int k = 0; k < N; k++) begin
                        ea = {m_tag[s][w], 3'(s), 1'(k), 2'b00};
                        exp_q.push_back('{1'b1, ea, m_data[s][w][k]});
                        g_mem[ea] = m_data[s][w][k];
                    end
                m_valid[s][w] = 0; m_dirty[s][w] = 0;
            end
        exp_q.push_back('{1'b1, 32'h0000_3100, 32'(m_hits)});
        @(posedge CLK); #1 halt = 1;
        cyc = 0;
        do begin @(negedge CLK); cyc++; end while (!flushed && cyc < 600);
        @(posedge CLK); #1 halt = 0;
        chk("flushed_seen", 32'(flushed), 32'd1);
        chk("flush_cycles", cyc, 2 + S * W + exp_q.size());
        cmp_txns("flush");
    endtask

    initial begin
        int cyc;
        bit got;
        CLK = 0; RST = 1; halt = 0; dmemREN = 0; dmemWEN = 0; dmemaddr = 0; dmemstore = 0;
        dwait = 0; dload = 0; wait_n = 0; wcnt = 0; chk_load = 0; p_busy = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_dhit", 32'(dhit), 0);      chk("rst_dmemload", dmemload, 0);
        chk("rst_flushed", 32'(flushed), 0); chk("rst_dREN", 32'(dREN), 0);
        chk("rst_dWEN", 32'(dWEN), 0);      chk("rst_daddr", daddr, 0);
        chk("rst_dstore", dstore, 0);
        @(posedge CLK); #1 RST = 0;

        access(0, 32'h40, 0);
        chk("pin_fetch0", act_q.size() > 0 ? act_q[0].a : 32'hX, 32'h40);
        chk("pin_fetch1", act_q.size() > 1 ? act_q[1].a : 32'hX, 32'h44);
        chk("pin_load40", last_load, 32'h5A5A_0040);
        chk("pin_hits1", m_hits, 1);

        access(1, 32'h44, 32'hDEAD_BEEF);
        access(0, 32'h44, 0);
        chk("pin_deadbeef", last_load, 32'hDEAD_BEEF);
        chk("line_dirty", 32'(dut.r_meta[0][0].dirty), 1);

        access(0, 32'h80, 0);
        access(0, 32'hC0, 0);
        access(1, 32'h100, 32'h1234_5678);
        access(0, 32'h40, 0);
        access(0, 32'h80, 0);
        access(0, 32'hC0, 0);
        access(0, 32'h140, 0);
        chk("pin_evict_addr", act_q.size() > 0 ? act_q[0].a : 32'hX, 32'h100);
        chk("pin_evict_data", act_q.size() > 0 ? act_q[0].d : 32'hX, 32'h1234_5678);
        chk("pin_refill", act_q.size() > 2 ? act_q[2].a : 32'hX, 32'h140);

        wait_n = 5;
        access(0, 32'h208, 0);
        access(1, 32'h188, 32'hA5A5_0001);
        access(0, 32'h1C8, 0);
        wait_n = 0;

        do_reset();
        access(1, 32'h008, 32'hCAFE_0008);
        access(0, 32'h018, 0);
        access(1, 32'h058, 32'hCAFE_0058);
        do_flush();
        chk("pin_fl0", act_q.size() > 0 ? act_q[0].a : 32'hX, 32'h008);
        chk("pin_fl2", act_q.size() > 2 ? act_q[2].a : 32'hX, 32'h058);
        chk("pin_cnt_addr", act_q.size() > 4 ? act_q[4].a : 32'hX, 32'h3100);
        chk("pin_cnt_val", act_q.size() > 4 ? act_q[4].d : 32'hX, 32'd3);
        for (int s = 0; s < S; s++)
            for (int w = 0; w < W; w++)
                chk($sformatf("valid_clear_s%0d_w%0d", s, w), 32'(dut.r_meta[s][w].valid), 0);
        dmemREN = 1; dmemaddr = 32'h008;
        repeat (3) begin
            @(negedge CLK);
            chk("done_flushed", 32'(flushed), 1);
            chk("done_dhit", 32'(dhit), 0);
            chk("done_dREN", 32'(dREN), 0);
        end
        dmemREN = 0;

        do_reset();
        @(posedge CLK); #1 dmemREN = 1; dmemaddr = 32'h40;
        cyc = 0; got = 0;
        while (!got && cyc < 50) begin
            @(negedge CLK);
            if (dREN && daddr == 32'h44) got = 1; else cyc++;
        end
        chk("rst_mid_reach", 32'(got), 1);
        #2 RST = 1; p_busy = 0; wcnt = 0;
        #1;
        chk("rstm_dREN", 32'(dREN), 0); chk("rstm_daddr", daddr, 0); chk("rstm_dhit", 32'(dhit), 0);
        @(posedge CLK); #1;
        chk("rstm_edge_dREN", 32'(dREN), 0); chk("rstm_edge_dWEN", 32'(dWEN), 0);
        chk("rstm_edge_dstore", dstore, 0);  chk("rstm_edge_flushed", 32'(flushed), 0);
        dmemREN = 0; model_reset();
        @(posedge CLK); #1 RST = 0;
        access(0, 32'h40, 0);
        chk("pin_refetch_count", act_q.size(), 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
